// File: rtl/chunk_arb_pkg.sv
// chunk_arb_pkg: shared types and sizing helpers for the chunk arbiter slice.
package chunk_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Number of M-bit chunks the chunker emits per L-bit word.
  function automatic int nr(input int l, input int m);
    return l / m;
  endfunction

  // Index width for n items, never narrower than one bit.
  function automatic int sw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or
// after ptr, wrapping modulo N.
module rr_arbiter
  import chunk_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int SW = sw(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt_idx
);

  localparam int unsigned NU = N;

  int unsigned cand;

  // Walk every offset from ptr; the first set request wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned off = 0; off < NU; off++) begin
      cand = (32'(ptr) + off) % NU;
      if (!gnt_valid && req[cand[SW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/chunk_arbiter.sv
// chunk_arbiter: shares one word-to-chunk converter between N requesters.
// A round-robin winner's word is latched and strobed into the chunker once;
// the NR returned chunks are forwarded tagged with source and last flag.
// Optional watchdog: define CHUNK_ARB_WATCHDOG_EN to abort a stalled DRAIN
// after TMO idle cycles and raise a sticky err.
module chunk_arbiter
  import chunk_arb_pkg::*;
#(
  parameter int L = 8,
  parameter int M = 2,
  parameter int N = 4,
`ifdef CHUNK_ARB_WATCHDOG_EN
  parameter int TMO = 16,
`endif
  localparam int SW = sw(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*L-1:0] data_in,
  output logic [N-1:0]   ack,
  output logic [L-1:0]   ch_data,
  output logic           ch_strobe,
  input  logic [M-1:0]   ch_q,
  input  logic           ch_valid,
  output logic [M-1:0]   q,
  output logic           q_valid,
  output logic [SW-1:0]  q_src,
  output logic           q_last,
  output logic           busy,
  output logic           err
);

  localparam int NR = nr(L, M);
  localparam int CW = sw(NR);

  if ((L % M) != 0) begin : g_chk_lm
    $error("chunk_arbiter: L (%0d) must be a multiple of M (%0d)", L, M);
  end
  if ((N < 1) || (N > 16)) begin : g_chk_n
    $error("chunk_arbiter: N (%0d) must be within 1..16", N);
  end

  state_e         state_q, state_d;
  logic [N-1:0]   ack_q, ack_d;
  logic [L-1:0]   data_q, data_d;
  logic           strobe_q, strobe_d;
  logic [SW-1:0]  src_q, src_d;
  logic [SW-1:0]  ptr_q, ptr_d;
  logic [SW-1:0]  qsrc_q, qsrc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   q_q, q_d;
  logic           qv_q, qv_d;
  logic           qlast_q, qlast_d;
  logic           gnt_valid;
  logic [SW-1:0]  gnt_idx;

`ifdef CHUNK_ARB_WATCHDOG_EN
  localparam int WW = sw(TMO);
  logic [WW-1:0]  wd_q, wd_d;
  logic           err_q, err_d;
`endif

  rr_arbiter #(
    .N(N)
  ) u_rr (
    .req       (req),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Next-state and registered-output computation for the IDLE/LOAD/DRAIN flow.
  always_comb begin
    state_d  = state_q;
    ack_d    = '0;
    data_d   = data_q;
    strobe_d = 1'b0;
    src_d    = src_q;
    ptr_d    = ptr_q;
    qsrc_d   = qsrc_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    qv_d     = 1'b0;
    qlast_d  = 1'b0;
`ifdef CHUNK_ARB_WATCHDOG_EN
    wd_d     = wd_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          ack_d[gnt_idx] = 1'b1;
          data_d  = data_in[gnt_idx*L +: L];
          src_d   = gnt_idx;
          ptr_d   = (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        strobe_d = 1'b1;
        cnt_d    = '0;
`ifdef CHUNK_ARB_WATCHDOG_EN
        wd_d     = '0;
`endif
        state_d  = DRAIN;
      end
      DRAIN: begin
        if (ch_valid) begin
          q_d    = ch_q;
          qv_d   = 1'b1;
          qsrc_d = src_q;
          cnt_d  = cnt_q + 1'b1;
`ifdef CHUNK_ARB_WATCHDOG_EN
          wd_d   = '0;
`endif
          if (cnt_q == CW'(NR-1)) begin
            qlast_d = 1'b1;
            state_d = IDLE;
          end
        end
`ifdef CHUNK_ARB_WATCHDOG_EN
        else if (wd_q == WW'(TMO-1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; async active-low reset clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ack_q    <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      src_q    <= '0;
      ptr_q    <= '0;
      qsrc_q   <= '0;
      cnt_q    <= '0;
      q_q      <= '0;
      qv_q     <= 1'b0;
      qlast_q  <= 1'b0;
`ifdef CHUNK_ARB_WATCHDOG_EN
      wd_q     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      src_q    <= src_d;
      ptr_q    <= ptr_d;
      qsrc_q   <= qsrc_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      qv_q     <= qv_d;
      qlast_q  <= qlast_d;
`ifdef CHUNK_ARB_WATCHDOG_EN
      wd_q     <= wd_d;
      err_q    <= err_d;
`endif
    end
  end

  assign ack       = ack_q;
  assign ch_data   = data_q;
  assign ch_strobe = strobe_q;
  assign q         = q_q;
  assign q_valid   = qv_q;
  assign q_src     = qsrc_q;
  assign q_last    = qlast_q;
  assign busy      = (state_q != IDLE);
`ifdef CHUNK_ARB_WATCHDOG_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_chunk_arbiter.sv
// tb_chunk_arbiter: randomized and directed checks of chunk_arbiter against a
// transaction-level reference (grant order, expected chunk stream, timeouts).
module tb_chunk_arbiter;

  localparam int L  = 8;
  localparam int M  = 2;
  localparam int N  = 4;
  localparam int NR = L / M;
  localparam int SW = 2;
`ifdef CHUNK_ARB_WATCHDOG_EN
  localparam int TMO = 16;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*L-1:0] data_in;
  logic [N-1:0]   ack;
  logic [L-1:0]   ch_data;
  logic           ch_strobe;
  logic [M-1:0]   ch_q;
  logic           ch_valid;
  logic [M-1:0]   q;
  logic           q_valid;
  logic [SW-1:0]  q_src;
  logic           q_last;
  logic           busy;
  logic           err;

  always #5 clk = ~clk;

  chunk_arbiter #(
    .L(L),
    .M(M),
    .N(N)
`ifdef CHUNK_ARB_WATCHDOG_EN
    , .TMO(TMO)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data_in   (data_in),
    .ack       (ack),
    .ch_data   (ch_data),
    .ch_strobe (ch_strobe),
    .ch_q      (ch_q),
    .ch_valid  (ch_valid),
    .q         (q),
    .q_valid   (q_valid),
    .q_src     (q_src),
    .q_last    (q_last),
    .busy      (busy),
    .err       (err)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [M-1:0] d;
    int           src;
    bit           last;
  } chunk_t;

  chunk_t         exp_q[$];
  int             glog[$];
  chunk_t         c;
  int             g;
  int             m_ptr = 0;
  int             quiet = 0;
  int             n_qv = 0;
  int             n_last = 0;
  bit             m_idle = 1'b1;
  bit             m_err = 1'b0;
  bit             strobe_pend = 1'b0;
  bit             in_drain = 1'b0;
  bit             just_strobed = 1'b0;
  logic [L-1:0]   m_word = '0;
  logic [N-1:0]   req_s = '0;
  logic [N*L-1:0] data_s = '0;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int glog_at(input int i);
    return (i < glog.size()) ? glog[i] : -1;
  endfunction

  // Monitor: sample away from the active edge, compare against the model.
  always @(negedge clk) begin
    if (!reset) begin
      m_idle = 1'b1; m_ptr = 0; strobe_pend = 1'b0; in_drain = 1'b0;
      quiet = 0; m_err = 1'b0; exp_q.delete();
    end else begin
      just_strobed = 1'b0;
      check_eq("ch_strobe", 64'(ch_strobe), 64'(strobe_pend));
      if (strobe_pend) begin
        check_eq("ch_data", 64'(ch_data), 64'(m_word));
        in_drain = 1'b1; quiet = 0; just_strobed = 1'b1; strobe_pend = 1'b0;
      end
      if (m_idle && req_s != '0) begin
        g = rr_pick(req_s, m_ptr);
        check_eq("ack_grant", 64'(ack), 64'(1) << g);
        glog.push_back(g);
        m_word = data_s[g*L +: L];
        m_ptr = (g + 1) % N;
        m_idle = 1'b0;
        strobe_pend = 1'b1;
        for (int k = 0; k < NR; k++) begin
          c.d = M'(m_word >> ((NR - 1 - k) * M));
          c.src = g;
          c.last = (k == NR - 1);
          exp_q.push_back(c);
        end
      end else begin
        check_eq("ack_none", 64'(ack), 64'(0));
      end
      if (q_valid) begin
        n_qv++;
        quiet = 0;
        if (q_last) n_last++;
        if (exp_q.size() == 0) begin
          check_eq("q_valid_unexpected", 64'(q_valid), 64'(0));
        end else begin
          c = exp_q.pop_front();
          check_eq("q", 64'(q), 64'(c.d));
          check_eq("q_src", 64'(q_src), 64'(c.src));
          check_eq("q_last", 64'(q_last), 64'(c.last));
          if (c.last) begin m_idle = 1'b1; in_drain = 1'b0; end
        end
      end else begin
        check_eq("q_last_without_valid", 64'(q_last), 64'(0));
`ifdef CHUNK_ARB_WATCHDOG_EN
        if (in_drain && !just_strobed) begin
          quiet++;
          if (quiet == TMO) begin
            m_err = 1'b1; m_idle = 1'b1; in_drain = 1'b0; exp_q.delete();
          end
        end
`endif
      end
      check_eq("err", 64'(err), 64'(m_err));
      check_eq("busy", 64'(busy), 64'(!m_idle));
    end
    req_s  = req;
    data_s = data_in;
  end

  // ---------------- chunker stand-in ----------------
  int           ck_left = 0;
  int           ck_gap = 0;
  int           ck_sent = 0;
  int           ck_stall = -1;
  int           gapmax = 0;
  bit           inject_en = 1'b0;
  logic [L-1:0] ck_word = '0;

  initial begin
    ch_valid = 1'b0;
    ch_q = '0;
    forever begin
      @(posedge clk); #2;
      ch_valid = 1'b0;
      if (!reset) begin
        ck_left = 0;
      end else if (ch_strobe) begin
        ck_word = ch_data; ck_left = NR; ck_sent = 0;
        ck_gap = int'($urandom_range(gapmax));
      end else if (ck_left > 0) begin
        if (ck_gap > 0) ck_gap--;
        else if (ck_sent != ck_stall) begin
          ch_valid = 1'b1;
          ch_q = M'(ck_word >> ((ck_left - 1) * M));
          ck_left--; ck_sent++;
          ck_gap = int'($urandom_range(gapmax));
        end
      end else if (inject_en && !busy && ($urandom_range(3) == 0)) begin
        ch_valid = 1'b1;
        ch_q = M'($urandom);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic set_word(input int i, input logic [L-1:0] w);
    data_in[i*L +: L] = w;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit done = 1'b0;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      tick();
      req = req & ~ack;
      done = (req == '0) && !busy && (exp_q.size() == 0);
    end
    check_eq(tag, 64'(done), 64'(1));
  endtask

  task automatic pulse_reset();
    @(negedge clk); #3 reset = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); #3 reset = 1'b1;
  endtask

  int base, nq, nl;

  initial begin
    #400000;
    $display("FAIL global_timeout: got time %0t expected completion before it", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; req = '0; data_in = '0;
    @(posedge clk); #1;
    check_eq("rst_ack", 64'(ack), 64'(0));
    check_eq("rst_strobe", 64'(ch_strobe), 64'(0));
    check_eq("rst_q_valid", 64'(q_valid), 64'(0));
    check_eq("rst_q_last", 64'(q_last), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_err", 64'(err), 64'(0));
    check_eq("rst_ch_data", 64'(ch_data), 64'(0));
    check_eq("rst_q", 64'(q), 64'(0));
    check_eq("rst_q_src", 64'(q_src), 64'(0));
    @(posedge clk); @(negedge clk); #3 reset = 1'b1;

    // single request from requester 2
    tick();
    set_word(2, 8'b01101001); req = 4'b0100;
    base = glog.size(); nl = n_last;
    wait_idle("t1_idle", 40);
    check_eq("t1_grants", 64'(glog.size() - base), 64'(1));
    check_eq("t1_winner", 64'(glog_at(base)), 64'(2));
    check_eq("t1_lasts", 64'(n_last - nl), 64'(1));

    // pointer now 3: 1001 grants 3 then wraps to 0
    tick();
    set_word(0, 8'h5A); set_word(3, 8'hC3); req = 4'b1001;
    base = glog.size();
    wait_idle("t2_idle", 60);
    check_eq("t2_first", 64'(glog_at(base)), 64'(3));
    check_eq("t2_wrap", 64'(glog_at(base + 1)), 64'(0));

    // requester 1 drops before it is ever granted
    tick();
    set_word(0, 8'h96); req = 4'b0001;
    base = glog.size();
    tick(); req = req & ~ack; req[1] = 1'b1;
    tick(); tick(); req[1] = 1'b0;
    wait_idle("t2b_idle", 40);
    check_eq("t2b_grants", 64'(glog.size() - base), 64'(1));
    check_eq("t2b_winner", 64'(glog_at(base)), 64'(0));

    // all four held permanently from pointer 0
    pulse_reset();
    tick();
    set_word(0, 8'hA5); set_word(1, 8'h3C); set_word(2, 8'hF0); set_word(3, 8'h0F);
    req = 4'b1111;
    base = glog.size();
    for (int cyc = 0; cyc < 200 && glog.size() < base + 5; cyc++) tick();
    req = '0;
    wait_idle("t3_idle", 40);
    for (int i = 0; i < 5; i++) check_eq("t3_order", 64'(glog_at(base + i)), 64'(i % N));

    // gaps between chunks and stray valids while idle
    gapmax = 2; inject_en = 1'b1;
    tick();
    set_word(1, 8'hB4); req = 4'b0010;
    nq = n_qv; nl = n_last;
    wait_idle("t4_idle", 60);
    check_eq("t4_chunks", 64'(n_qv - nq), 64'(NR));
    check_eq("t4_lasts", 64'(n_last - nl), 64'(1));
    nq = n_qv;
    repeat (20) tick();
    check_eq("t4_inject_idle", 64'(n_qv - nq), 64'(0));

    // reset in the middle of DRAIN
    gapmax = 0;
    tick();
    set_word(1, 8'hE7); req = 4'b0010;
    nq = n_qv;
    tick(); req = req & ~ack;
    for (int cyc = 0; cyc < 60 && n_qv < nq + 2; cyc++) begin
      @(negedge clk); #1;
    end
    check_eq("t5_two_chunks", 64'(n_qv >= nq + 2), 64'(1));
    #2 reset = 1'b0;
    #1;
    check_eq("t5_ack", 64'(ack), 64'(0));
    check_eq("t5_q_valid", 64'(q_valid), 64'(0));
    check_eq("t5_q", 64'(q), 64'(0));
    check_eq("t5_q_src", 64'(q_src), 64'(0));
    check_eq("t5_q_last", 64'(q_last), 64'(0));
    check_eq("t5_busy", 64'(busy), 64'(0));
    check_eq("t5_ch_data", 64'(ch_data), 64'(0));
    @(posedge clk); @(posedge clk);
    @(negedge clk); #3 reset = 1'b1;
    tick();
    for (int i = 0; i < N; i++) set_word(i, L'($urandom));
    req = 4'b1111;
    base = glog.size();
    wait_idle("t5_idle", 100);
    check_eq("t5_restart", 64'(glog_at(base)), 64'(0));

    // randomized traffic
    gapmax = 2; inject_en = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          if ($urandom_range(3) == 0) set_word(i, L'($urandom));
          else req[i] = 1'b0;
        end else if (!req[i] && ($urandom_range(7) == 0)) begin
          set_word(i, L'($urandom));
          req[i] = 1'b1;
        end else if (req[i] && ($urandom_range(40) == 0)) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;
    wait_idle("rand_drain", 200);

`ifdef CHUNK_ARB_WATCHDOG_EN
    // chunker stalls after two chunks
    gapmax = 0; inject_en = 1'b0; ck_stall = 2;
    tick();
    set_word(2, 8'h4D); req = 4'b0100;
    nl = n_last;
    for (int cyc = 0; cyc < 80 && !err; cyc++) begin
      tick();
      req = req & ~ack;
    end
    check_eq("wd_err", 64'(err), 64'(1));
    check_eq("wd_idle", 64'(busy), 64'(0));
    check_eq("wd_no_last", 64'(n_last - nl), 64'(0));
    ck_stall = -1;
    tick();
    set_word(0, 8'h81); req = 4'b0001;
    wait_idle("wd_next_idle", 60);
    check_eq("wd_next_last", 64'(n_last - nl), 64'(1));
    check_eq("wd_err_sticky", 64'(err), 64'(1));
`endif

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/chunk_arbiter.md
Name: chunk_arbiter

Overview:
- Shares one chunker (L-bit word in on strobe, NR=L/M chunks of M bits out MSB-first, each with valid) between N requesters.
- Round-robin grant; the granted word is latched and the chunker strobed once.
- Exactly NR valid chunks are counted; each forwarded chunk is tagged with source index and a last flag.
- Sits between the raw-bit sources and the Toeplitz hashing datapath.

Parameters:
- L, 8, word width fed to the chunker
- M, 2, chunk width; L mod M must be 0 (elaboration error otherwise)
- N, 4, number of requesters, 1..16
- SW, $clog2(N) (min 1), source-index width (derived localparam)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req  in  N  per-requester request level; held until ack
- data_in  in  N*L  requester words; requester i at [i*L +: L]
- ack  out  N  one-cycle one-hot pulse: word from requester i captured
- ch_data  out  L  word to chunker, held stable from strobe until the last chunk
- ch_strobe  out  1  one-cycle load pulse to chunker
- ch_q  in  M  chunk from chunker
- ch_valid  in  1  chunk valid from chunker
- q  out  M  forwarded chunk
- q_valid  out  1  forwarded chunk valid
- q_src  out  SW  requester index of current chunk
- q_last  out  1  high with the NR-th chunk of a word
- busy  out  1  high outside IDLE
- err  out  1  sticky watchdog error (see Optional Feature)

Behaviour:
- Reset (reset=0, async): state=IDLE; ack, ch_strobe, q_valid, q_last, busy, err = 0; ch_data, q, q_src = 0; rr pointer = 0; chunk count = 0.
- States: IDLE, LOAD, DRAIN.
- IDLE: if any req, pick the first set bit at or after the rr pointer, wrapping modulo N. On the next edge:
  - ack[g]=1, ch_data=data_in[g], src=g, state=LOAD.
  - rr pointer = (g+1) mod N.
  - Grant latency: req high at edge k gives ack at edge k+1.
- LOAD: ch_strobe=1 for exactly this one cycle, ack=0, count=0. Next state DRAIN.
- DRAIN, each cycle with ch_valid=1 (one-cycle registered forwarding):
  - q=ch_q, q_valid=1, q_src=src, count++.
  - If count==NR-1 before the increment: q_last=1, state=IDLE.
- DRAIN: ch_valid pulses are counted, not assumed consecutive. Gaps are allowed.
- ch_valid outside DRAIN is ignored: no q_valid.
- Simultaneous req and final chunk: arbitration happens only in IDLE. Back-to-back words therefore have a minimum spacing of NR+2 cycles plus chunker latency.
- A requester dropping req before ack loses its turn with no side effects. A req still held after ack is treated as a new request.
- Reset mid-DRAIN: immediate return to IDLE and all outputs cleared. The chunker shares the reset, so no stale chunks are forwarded.
- busy = (state != IDLE).

Optional Feature:
- Macro CHUNK_ARB_WATCHDOG_EN.
- Defined:
  - Parameter TMO (default 16) and a cycle counter cleared on entering DRAIN and on each ch_valid.
  - If it reaches TMO in DRAIN: err=1 (sticky until reset), state=IDLE, no q_last emitted.
- Undefined: no counter; err tied to 0; DRAIN waits indefinitely.

Decomposition:
- Package chunk_arb_pkg holds:
  - state enum (IDLE, LOAD, DRAIN)
  - function nr(L,M)=L/M
  - function sw(N)=max(1,$clog2(N))
- One sub-module: rr_arbiter.
  - Parameter N.
  - Inputs: req, ptr.
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational, fully enumerated wrap search.

Test Plan:
- Single request (L=8, M=2, N=4): req[2]=1, data_in[2]=8'b01101001. Required: ack=4'b0100 one cycle; ch_strobe once; q sequence 01,10,10,01 with q_src=2; q_last on the 4th chunk; busy back to 0.
- All four req held permanently, words A5,3C,F0,0F. Required: grants in order 0,1,2,3,0; each word's 4 chunks carry the correct q_src; no interleaving between words.
- Chunker model inserts 2-cycle gaps between valids. Required: still exactly 4 q_valid per word, q_last on the 4th; a ch_valid injected while IDLE produces no q_valid.
- Pointer=3 and req=4'b1001. Required: grant goes to 3, then 0 (wrap); req dropped before ack yields no ack for that requester.
- reset pulsed low mid-DRAIN after 2 chunks. Required: outputs 0 asynchronously; after release, a new req restarts from rr pointer 0.
- With CHUNK_ARB_WATCHDOG_EN and TMO=16: chunker gives 2 valids, then stops. Required: 16 cycles later err=1, state IDLE, no q_last; the next req is served normally and err stays 1.
